// File: rtl/memory_slave_if.sv
// Request/response bus between the memory-model driver and memory_slave.
//
// Handshake: the master raises req with wr/addr/wdata valid; the slave takes
// the request on a rising edge only when it is idle (busy=0). A request seen
// while busy=1 is dropped, so the master must watch busy to know whether it
// was taken. Each taken request ends with exactly one slv_rsp pulse, during
// which err and (for reads) rdata are valid.
interface memory_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  slv_rsp;
    logic                  err;
    logic                  busy;

    modport master (
        output req, wr, addr, wdata,
        input  rdata, slv_rsp, err, busy
    );

    modport slave (
        input  req, wr, addr, wdata,
        output rdata, slv_rsp, err, busy
    );
endinterface

// File: rtl/memory_slave.sv
// Single-beat memory responder. Accepts one request at a time, performs it
// against a MEM_SIZE-word array and answers with a one-cycle slv_rsp pulse.
// Writes answer one cycle after accept, reads RD_LATENCY cycles after accept.
// Reset clears the whole array and aborts any request in flight.
module memory_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    memory_slave_if.slave  bus,
    output logic [1:0]     state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);
    // WAIT lasts RD_LATENCY-1 cycles; the counter exits on reaching zero.
    localparam logic [1:0] CNT_INIT = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

    state_t                state;
    state_t                state_n;
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
    logic [1:0]            wait_cnt;
    logic                  is_rd_q;
    logic                  err_cap_q;
    logic [DATA_WIDTH-1:0] rd_cap_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  slv_rsp_q;
    logic                  err_q;
    logic                  busy_q;

    logic                  accept;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] mem_word;

    assign accept   = (state == ST_IDLE) && bus.req;
    assign in_range = ({1'b0, bus.addr} < MEM_LIMIT);
    assign idx      = bus.addr[IDX_W-1:0];
    // Out-of-range reads return zero rather than an aliased word.
    assign mem_word = in_range ? mem[idx] : '0;

    // State register; reset aborts whatever request is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode: writes and latency-1 reads go straight to RESP.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    if (bus.wr || (RD_LATENCY == 1)) begin
                        state_n = ST_RESP;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 2'd0) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Array, request capture and registered outputs, all keyed off next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem[i] <= '0;
            end
            wait_cnt  <= 2'd0;
            is_rd_q   <= 1'b0;
            err_cap_q <= 1'b0;
            rd_cap_q  <= '0;
            rdata_q   <= '0;
            slv_rsp_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            busy_q    <= (state_n != ST_IDLE);
            slv_rsp_q <= (state_n == ST_RESP);

            if (accept) begin
                is_rd_q   <= !bus.wr;
                err_cap_q <= !in_range;
                rd_cap_q  <= mem_word;
                wait_cnt  <= CNT_INIT;
                if (bus.wr && in_range) begin
                    mem[idx] <= bus.wdata;
                end
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 2'd1;
            end

            if (state_n == ST_RESP) begin
                err_q <= accept ? !in_range : err_cap_q;
            end else begin
                err_q <= 1'b0;
            end

            // rdata only moves on a read response and then holds.
            if (state_n == ST_RESP) begin
                if (accept && !bus.wr) begin
                    rdata_q <= mem_word;
                end else if (!accept && is_rd_q) begin
                    rdata_q <= rd_cap_q;
                end
            end
        end
    end

    assign bus.rdata   = rdata_q;
    assign bus.slv_rsp = slv_rsp_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;
    assign state_dbg   = state;

endmodule
